// File: rtl/rx_frame_checker_if.sv
// Receive-side bus of the frame checker: frame strobe and mode in, checked
// entries (valid/ready), error counters and overrun flag out.
interface rx_frame_checker_if #(
    parameter int DATA_W = 8,
    parameter int STOP_W = 1,
    parameter int CNT_W  = 16
);
    localparam int FRAME_W = DATA_W + 2 + STOP_W;

    logic [2:0]         i_Parity;
    logic [FRAME_W-1:0] i_Frame;
    logic               i_Frame_valid;
    logic               i_Ready;
    logic               i_ClrCnt;
    logic               o_Valid;
    logic [DATA_W-1:0]  o_Data;
    logic               o_ParityOK;
    logic               o_FrameOK;
    logic [CNT_W-1:0]   o_ParErrCnt;
    logic [CNT_W-1:0]   o_FrmErrCnt;
    logic               o_Overrun;

    modport slave (
        input  i_Parity, i_Frame, i_Frame_valid, i_Ready, i_ClrCnt,
        output o_Valid, o_Data, o_ParityOK, o_FrameOK,
               o_ParErrCnt, o_FrmErrCnt, o_Overrun
    );

    modport master (
        output i_Parity, i_Frame, i_Frame_valid, i_Ready, i_ClrCnt,
        input  o_Valid, o_Data, o_ParityOK, o_FrameOK,
               o_ParErrCnt, o_FrmErrCnt, o_Overrun
    );
endinterface

// File: rtl/rx_frame_checker.sv
// USRT receive-frame checker: stage 1 checks framing/parity and strips data,
// stage 2 enqueues into a small output FIFO and updates error statistics.
module rx_frame_checker #(
    parameter int DATA_W     = 8,
    parameter int STOP_W     = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              i_Pclk,
    input  logic              i_Rst_n,
    rx_frame_checker_if.slave bus
);
    localparam int FRAME_W = DATA_W + 2 + STOP_W;
    localparam int AW      = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              pok;
        logic              fok;
    } entry_t;

    // ---------------- stage 1: check ----------------
    entry_t            s1_d, s1_q;
    logic              s1_vld_q;
    logic [DATA_W-1:0] f_data;
    logic              f_slot;

    assign f_data = bus.i_Frame[DATA_W:1];
    assign f_slot = bus.i_Frame[DATA_W+1];

    always_comb begin
        s1_d      = '0;
        s1_d.data = f_data;
        s1_d.fok  = ~bus.i_Frame[0] & (&bus.i_Frame[FRAME_W-1 -: STOP_W]);
        case (bus.i_Parity)
            3'b001:  s1_d.pok = ~(^f_data ^ f_slot);
            3'b010:  s1_d.pok = ^f_data ^ f_slot;
            3'b011:  s1_d.pok = f_slot;
            3'b100:  s1_d.pok = ~f_slot;
            default: s1_d.pok = 1'b1;
        endcase
    end

    always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            s1_vld_q <= 1'b0;
            s1_q     <= '0;
        end else begin
            s1_vld_q <= bus.i_Frame_valid;
            if (bus.i_Frame_valid) s1_q <= s1_d;
        end
    end

    // ---------------- stage 2: FIFO ----------------
    entry_t          mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     cnt_q, cnt_d;
    logic            valid, full, pop, push, drop;
    entry_t          head;

    assign valid = (cnt_q != '0);
    assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign pop   = valid & bus.i_Ready;
    // A pop on the same edge frees the slot a full FIFO would otherwise refuse.
    assign push  = s1_vld_q & (~full | pop);
    assign drop  = s1_vld_q & full & ~pop;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_Pclk) begin
        if (push) mem_q[wr_ptr_q] <= s1_q;
    end

    // ---------------- statistics ----------------
    logic [CNT_W-1:0] par_cnt_q, frm_cnt_q;
    logic             ovr_q;

    always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            par_cnt_q <= '0;
            frm_cnt_q <= '0;
            ovr_q     <= 1'b0;
        end else if (bus.i_ClrCnt) begin
            par_cnt_q <= '0;
            frm_cnt_q <= '0;
            ovr_q     <= 1'b0;
        end else begin
            if (s1_vld_q && !s1_q.pok && par_cnt_q != {CNT_W{1'b1}})
                par_cnt_q <= par_cnt_q + 1'b1;
            if (s1_vld_q && !s1_q.fok && frm_cnt_q != {CNT_W{1'b1}})
                frm_cnt_q <= frm_cnt_q + 1'b1;
            if (drop) ovr_q <= 1'b1;
        end
    end

    // Head fields are forced to zero when empty so stale RAM never shows.
    assign head            = mem_q[rd_ptr_q];
    assign bus.o_Valid     = valid;
    assign bus.o_Data      = valid ? head.data : '0;
    assign bus.o_ParityOK  = valid & head.pok;
    assign bus.o_FrameOK   = valid & head.fok;
    assign bus.o_ParErrCnt = par_cnt_q;
    assign bus.o_FrmErrCnt = frm_cnt_q;
    assign bus.o_Overrun   = ovr_q;
endmodule

// File: tb/tb_rx_frame_checker.sv
// Bench for rx_frame_checker: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_rx_frame_checker;
    localparam int DATA_W = 8;
    localparam int STOP_W = 2;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 2;
    localparam int FW     = DATA_W + 2 + STOP_W;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rx_frame_checker_if #(.DATA_W(DATA_W), .STOP_W(STOP_W), .CNT_W(CNT_W)) bus ();

    rx_frame_checker #(.DATA_W(DATA_W), .STOP_W(STOP_W), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_Pclk (clk),
        .i_Rst_n(rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [DATA_W-1:0] d;
        bit                p;
        bit                f;
    } ent_t;

    // ---------------- reference model ----------------
    ent_t q[$];
    ent_t s1e;
    bit   s1v;
    int   pcnt, fcnt;
    bit   ovr;

    function automatic ent_t mdl(input logic [FW-1:0] fr, input logic [2:0] m);
        ent_t e;
        int   ones;
        bit   s;
        e.d  = fr[DATA_W:1];
        s    = fr[DATA_W+1];
        ones = $countones(fr[DATA_W:1]) + int'(s);
        case (m)
            3'd1:    e.p = (ones % 2 == 0);
            3'd2:    e.p = (ones % 2 == 1);
            3'd3:    e.p = s;
            3'd4:    e.p = !s;
            default: e.p = 1'b1;
        endcase
        e.f = (fr[0] == 1'b0) && (fr[FW-1 -: STOP_W] == {STOP_W{1'b1}});
        return e;
    endfunction

    always @(negedge rst_n) begin
        q.delete();
        s1v  = 0;
        pcnt = 0;
        fcnt = 0;
        ovr  = 0;
    end

    always @(posedge clk) begin
        bit pop;
        if (rst_n) begin
            pop = (q.size() != 0) && bus.i_Ready;
            if (pop) void'(q.pop_front());
            if (s1v) begin
                if (!s1e.p && pcnt < MAXC) pcnt++;
                if (!s1e.f && fcnt < MAXC) fcnt++;
                if (q.size() < DEPTH) q.push_back(s1e);
                else ovr = 1;
            end
            if (bus.i_ClrCnt) begin
                pcnt = 0;
                fcnt = 0;
                ovr  = 0;
            end
            s1v = bus.i_Frame_valid;
            if (bus.i_Frame_valid) s1e = mdl(bus.i_Frame, bus.i_Parity);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("valid", 32'(bus.o_Valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("data", 32'(bus.o_Data), 32'(q[0].d));
            chk("pok", 32'(bus.o_ParityOK), 32'(q[0].p));
            chk("fok", 32'(bus.o_FrameOK), 32'(q[0].f));
        end
        chk("perr", 32'(bus.o_ParErrCnt), 32'(pcnt));
        chk("ferr", 32'(bus.o_FrmErrCnt), 32'(fcnt));
        chk("ovr", 32'(bus.o_Overrun), 32'(ovr));
    end

    // ---------------- stimulus ----------------
    function automatic logic [FW-1:0] mkf(input logic [7:0] d, input logic slot,
                                          input logic st, input logic [1:0] sp);
        return {sp, slot, d, st};
    endfunction

    task automatic send(input logic [FW-1:0] fr, input logic [2:0] m);
        bus.i_Frame       = fr;
        bus.i_Parity      = m;
        bus.i_Frame_valid = 1'b1;
        @(negedge clk);
        bus.i_Frame_valid = 1'b0;
    endtask

    task automatic clr();
        bus.i_ClrCnt = 1'b1;
        @(negedge clk);
        bus.i_ClrCnt = 1'b0;
    endtask

    logic [2:0]  modes [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd7};
    logic [11:0] pat = 12'b0110_0110_1111;

    initial begin
        rst_n             = 1'b0;
        bus.i_Frame       = '0;
        bus.i_Parity      = '0;
        bus.i_Frame_valid = 1'b0;
        bus.i_Ready       = 1'b1;
        bus.i_ClrCnt      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus.o_Valid), 0);
        chk("rst_data", 32'(bus.o_Data), 0);
        chk("rst_perr", 32'(bus.o_ParErrCnt), 0);
        chk("rst_ovr", 32'(bus.o_Overrun), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: basic even-parity frame, latency N+2
        send(mkf(8'hA5, 1'b0, 1'b0, 2'b11), 3'd1);
        chk("t1_not_yet", 32'(bus.o_Valid), 0);
        @(negedge clk);
        chk("t1_valid", 32'(bus.o_Valid), 1);
        chk("t1_data", 32'(bus.o_Data), 32'hA5);
        chk("t1_pok", 32'(bus.o_ParityOK), 1);
        chk("t1_fok", 32'(bus.o_FrameOK), 1);
        @(negedge clk);
        chk("t1_perr", 32'(bus.o_ParErrCnt), 0);

        // 2: parity modes, data 8'h01, slot 0 then 1
        for (int k = 0; k < 12; k++) begin
            send(mkf(8'h01, 1'(k % 2), 1'b0, 2'b11), modes[k/2]);
            @(negedge clk);
            chk($sformatf("t2_pok%0d", k), 32'(bus.o_ParityOK), 32'(pat[11-k]));
            if (k == 5) begin
                chk("t2_perr_a", 32'(bus.o_ParErrCnt), 3);
                clr();
            end
        end
        chk("t2_perr_b", 32'(bus.o_ParErrCnt), 1);

        // 3: framing errors
        send(mkf(8'h3C, 1'b0, 1'b1, 2'b11), 3'd0);
        @(negedge clk);
        chk("t3_fok_a", 32'(bus.o_FrameOK), 0);
        chk("t3_data_a", 32'(bus.o_Data), 32'h3C);
        send(mkf(8'hC3, 1'b0, 1'b0, 2'b01), 3'd0);
        @(negedge clk);
        chk("t3_fok_b", 32'(bus.o_FrameOK), 0);
        chk("t3_data_b", 32'(bus.o_Data), 32'hC3);
        chk("t3_ferr", 32'(bus.o_FrmErrCnt), 2);
        clr();

        // 4: overrun with i_Ready low, then drain in order
        bus.i_Ready = 1'b0;
        for (int i = 0; i < 6; i++) send(mkf(8'(8'h10 + i), 1'b0, 1'b0, 2'b11), 3'd0);
        @(negedge clk);
        chk("t4_ovr", 32'(bus.o_Overrun), 1);
        chk("t4_head", 32'(bus.o_Data), 32'h10);
        bus.i_Ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t4_drain%0d", k), 32'(bus.o_Data), 32'(8'h10 + k));
            @(negedge clk);
        end
        chk("t4_empty", 32'(bus.o_Valid), 0);
        clr();
        // full + pop + write on the same edge
        bus.i_Ready = 1'b0;
        for (int i = 0; i < 5; i++) send(mkf(8'(8'h20 + i), 1'b0, 1'b0, 2'b11), 3'd0);
        bus.i_Ready = 1'b1;
        @(negedge clk);
        chk("t4_noovr", 32'(bus.o_Overrun), 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t4_coin%0d", k), 32'(bus.o_Data), 32'(8'h21 + k));
            @(negedge clk);
        end
        chk("t4_empty2", 32'(bus.o_Valid), 0);

        // 5: saturation and clear-wins
        clr();
        for (int i = 0; i < 5; i++) send(mkf(8'h01, 1'b0, 1'b0, 2'b11), 3'd1);
        @(negedge clk);
        chk("t5_sat", 32'(bus.o_ParErrCnt), 3);
        clr();
        send(mkf(8'h01, 1'b0, 1'b0, 2'b11), 3'd1);
        clr();
        chk("t5_clrwin", 32'(bus.o_ParErrCnt), 0);

        // 6: reset with 3 queued and one in stage 1
        bus.i_Ready = 1'b0;
        for (int i = 0; i < 4; i++) send(mkf(8'(8'h40 + i), 1'b1, 1'b0, 2'b11), 3'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(bus.o_Valid), 0);
        chk("t6_data", 32'(bus.o_Data), 0);
        chk("t6_perr", 32'(bus.o_ParErrCnt), 0);
        @(negedge clk);
        rst_n       = 1'b1;
        bus.i_Ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_stale", 32'(bus.o_Valid), 0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            logic [FW-1:0] fr;
            fr = FW'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                fr[0]             = 1'b0;
                fr[FW-1 -: STOP_W] = '1;
            end
            bus.i_Frame       = fr;
            bus.i_Parity      = 3'($urandom_range(0, 7));
            bus.i_Frame_valid = ($urandom_range(0, 9) < 7);
            bus.i_Ready       = ($urandom_range(0, 9) < 5);
            bus.i_ClrCnt      = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        bus.i_Frame_valid = 1'b0;
        bus.i_ClrCnt      = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
